uart_txd: RTL and testbench

- 8N1 UART transmitter: serialises bytes onto txd as 1 start bit, 8 data bits LSB first, and 1 stop bit.
- This is the stage directly upstream of the UART receiver: txd drives the receiver's serial input.
- Contains its own baud divider, a one-byte holding register and a valid/ready input handshake, so back-to-back frames go out with no idle gap.

---
 rtl/uart_txd.sv | 135 +++++++++++++
 tb/tb_uart_txd.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_txd.sv
// uart_txd: 8N1 UART transmitter with an integrated baud divider and a
// one-byte holding register, so back-to-back frames leave with no idle gap.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   tx_valid   upstream offers a byte on tx_data
//   tx_data    byte to send, captured only on an accepted handshake
//   tx_ready   holding register empty, a byte can be accepted
//   txd        serial line out (idles high)
//   busy       a frame is in progress or a byte is held
//   baud_tick  high during the last clock of each bit period of a frame
module uart_txd #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy,
  output logic       baud_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       hold;
  logic             hold_full;
  logic             bit_end;

  // Decodes of registered state only; no path from tx_valid to tx_ready.
  assign bit_end   = (cnt == CNT_LAST);
  assign tx_ready  = ~hold_full;
  assign busy      = (state != IDLE) || hold_full;
  assign baud_tick = (state != IDLE) && bit_end;

  // Frame sequencer, baud counter and holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      txd       <= 1'b1;
    end else begin
      // Accept only while empty; a transfer needs hold_full=1, so the two
      // never happen on the same edge.
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          txd     <= 1'b1;
          if (hold_full) begin
            state     <= START;
            shift     <= hold;
            hold_full <= 1'b0;
            txd       <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            txd     <= shift[0];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shift[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A held byte starts immediately, keeping frames contiguous.
            if (hold_full) begin
              state     <= START;
              shift     <= hold;
              hold_full <= 1'b0;
              txd       <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_txd.sv
// tb_uart_txd: drives directed and random handshakes into uart_txd and
// compares every output on every cycle against a frame-timeline model.
module tb_uart_txd;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       txd;
  logic       busy;
  logic       baud_tick;

  uart_txd #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .txd       (txd),
    .busy      (busy),
    .baud_tick (baud_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: cycles left in the current frame, the frame's 10 line levels,
  // and the holding register.
  int         m_remain;
  bit         m_hold;
  logic [7:0] m_hold_data;
  logic [9:0] m_frame;
  bit         m_acc;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit r);
    bit ready_pre;
    if (r) begin
      m_remain = 0;
      m_hold   = 0;
      m_acc    = 0;
      return;
    end
    ready_pre = !m_hold;
    m_acc     = 0;
    if (m_hold && m_remain <= 1) begin
      m_frame  = {1'b1, m_hold_data, 1'b0};
      m_remain = FRAME;
      m_hold   = 0;
    end else if (m_remain > 0) begin
      m_remain--;
    end
    if (v && ready_pre) begin
      m_hold      = 1;
      m_hold_data = d;
      m_acc       = 1;
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit r);
    int   pos;
    logic e_txd;
    logic e_tick;
    reset    = r;
    tx_valid = v;
    tx_data  = d;
    @(posedge clk);
    model_step(v, d, r);
    @(negedge clk);
    pos    = FRAME - m_remain;
    e_txd  = (m_remain > 0) ? m_frame[pos / CPB] : 1'b1;
    e_tick = (m_remain > 0) && ((pos % CPB) == CPB - 1);
    check_eq("txd",       8'(txd),       8'(e_txd));
    check_eq("tx_ready",  8'(tx_ready),  8'(!m_hold));
    check_eq("busy",      8'(busy),      8'((m_remain > 0) || m_hold));
    check_eq("baud_tick", 8'(baud_tick), 8'(e_tick));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0);
  endtask

  // Hold tx_valid with byte b until the model says it was taken.
  task automatic offer(input logic [7:0] b);
    int k;
    k = 0;
    do begin
      cycle(1, b, 0);
      k++;
    end while (!m_acc && k < 200);
    check_eq("offer_accepted", 8'(m_acc), 8'(1));
  endtask

  initial begin
    int k;
    m_remain    = 0;
    m_hold      = 0;
    m_hold_data = '0;
    m_frame     = '1;
    m_acc       = 0;
    reset       = 1'b1;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;

    // Reset and quiet line.
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 1);
    idle(50);

    // Single frame 0xA5.
    offer(8'hA5);
    idle(45);

    // Contiguous 0x00, 0xFF, 0x3C with valid held high.
    offer(8'h00);
    offer(8'hFF);
    offer(8'h3C);
    idle(130);

    // Reset during data bit 3 of 0xA5 while 0x55 is held.
    offer(8'hA5);
    offer(8'h55);
    k = 0;
    while (!(m_remain > 0 && (FRAME - m_remain) == 17) && k < 200) begin
      cycle(0, 8'h00, 0);
      k++;
    end
    check_eq("reach_bit3", 8'(k < 200), 8'(1));
    cycle(0, 8'h00, 1);
    idle(100);

    // tx_data changes right after acceptance.
    offer(8'h81);
    cycle(0, 8'hFF, 0);
    for (int i = 0; i < 44; i++) cycle(0, 8'hFF, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom % 3) != 0, 8'($urandom), ($urandom % 600) == 0);
    end
    idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
